// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared defaults and FSM encoding for the SRAM round-robin arbiter
package sram_arb_pkg;
  localparam int DATA_WIDTH_DEF = 2;
  localparam int ADDR_WIDTH_DEF = 4;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, pointer breaks ties, one-hot grant
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
  assign gnt_o[1] = valid_i[1] & (~valid_i[0] |  ptr_i);
endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: clears the SRAM after reset, then shares its single port between two requesters
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_web,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_din,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_web,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_din,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_dout,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] ADDR0,
  output logic [DATA_WIDTH-1:0] DIN0,
  input  logic [DATA_WIDTH-1:0] DOUT0
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, dout_q;
  logic                  ptr_q, ptr_d, csb_q, csb_d, web_q, web_d, run;
  logic [1:0]            gnt, rd_q, rd_d, rsp_q;
  assign run        = state_q == RUN;
  assign req0_ready = run & gnt[0];
  assign req1_ready = run & gnt[1];
  assign init_done  = run;
  assign csb0       = csb_q;
  assign web0       = web_q;
  assign ADDR0      = addr_q;
  assign DIN0       = din_q;
  assign rsp0_valid = rsp_q[0];
  assign rsp1_valid = rsp_q[1];
  assign rsp_dout   = dout_q;
  rr_arb2 u_arb (
    .valid_i({req1_valid, req0_valid}),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = '0;
    if (!run) begin
      csb_d   = 1'b0;
      web_d   = 1'b0;
      addr_d  = cnt_q;
      din_d   = '0;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == LAST_ADDR ? RUN : INIT;
    end else if (|gnt) begin
      csb_d  = 1'b0;
      web_d  = gnt[1] ? req1_web  : req0_web;
      addr_d = gnt[1] ? req1_addr : req0_addr;
      din_d  = gnt[1] ? req1_din  : req0_din;
      ptr_d  = gnt[0];
      rd_d   = gnt & {2{web_d}};
    end
  end
  // rd_q marks the read the SRAM serves this cycle; rsp_q captures its data one edge later
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= '0;
      rsp_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      rsp_q   <= rd_q;
      if (|rd_q) dout_q <= DOUT0;
    end
  end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: random and directed traffic against a transaction-level model of the arbiter
module tb_sram_rr_arbiter;
  logic       clk0 = 1'b0, rstb0 = 1'b1;
  logic       tv[2], tw[2];
  logic [3:0] ta[2];
  logic [1:0] td[2];
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, csb0, web0;
  logic [1:0] rsp_dout, DIN0, DOUT0;
  logic [3:0] ADDR0;
  logic [1:0] sram[16];
  typedef struct {int due; int id; int data;} rsp_t;
  rsp_t exp_q[$];
  int   ref_mem[16];
  int   checks = 0, failures = 0, n = 0, init_k = 0, ptr = 0, last_dout = 0;
  sram_rr_arbiter dut (
    .clk0(clk0), .rstb0(rstb0),
    .req0_valid(tv[0]), .req0_ready(req0_ready), .req0_web(tw[0]), .req0_addr(ta[0]), .req0_din(td[0]),
    .req1_valid(tv[1]), .req1_ready(req1_ready), .req1_web(tw[1]), .req1_addr(ta[1]), .req1_din(td[1]),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_dout(rsp_dout), .init_done(init_done),
    .csb0(csb0), .web0(web0), .ADDR0(ADDR0), .DIN0(DIN0), .DOUT0(DOUT0)
  );
  always #5 clk0 = ~clk0;
  assign DOUT0 = sram[ADDR0];
  always @(posedge clk0) if (!csb0 && !web0) sram[ADDR0] <= DIN0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1'b0; tw[i] = 1'b1; ta[i] = '0; td[i] = '0;
    end
  endtask
  task automatic rand_in();
    for (int i = 0; i < 2; i++) begin
      tv[i] = $urandom_range(0, 3) != 0;
      tw[i] = $urandom_range(0, 1) != 0;
      ta[i] = 4'($urandom_range(0, 7));
      td[i] = 2'($urandom_range(0, 3));
    end
  endtask
  // One clock cycle: inputs already driven; check ready, then the loaded command and any due response
  task automatic step();
    int g;
    #1;
    g = -1;
    if (init_k == 16) g = (tv[0] && tv[1]) ? ptr : tv[0] ? 0 : tv[1] ? 1 : -1;
    check("ready0", req0_ready, g == 0);
    check("ready1", req1_ready, g == 1);
    @(posedge clk0);
    #1;
    n++;
    if (init_k < 16) begin
      check("init_csb", csb0, 0);
      check("init_web", web0, 0);
      check("init_addr", ADDR0, init_k);
      check("init_din", DIN0, 0);
      ref_mem[init_k] = 0;
      init_k++;
    end else if (g >= 0) begin
      check("cmd_csb", csb0, 0);
      check("cmd_web", web0, tw[g]);
      check("cmd_addr", ADDR0, ta[g]);
      if (!tw[g]) check("cmd_din", DIN0, td[g]);
      ptr = 1 - g;
      if (tw[g]) exp_q.push_back('{n + 1, g, ref_mem[ta[g]]});
      else ref_mem[ta[g]] = td[g];
    end else begin
      check("idle_csb", csb0, 1);
      check("idle_web", web0, 1);
    end
    check("init_done", init_done, init_k == 16);
    if (exp_q.size() > 0 && exp_q[0].due == n) begin
      rsp_t e = exp_q.pop_front();
      check("rsp0_valid", rsp0_valid, e.id == 0);
      check("rsp1_valid", rsp1_valid, e.id == 1);
      check("rsp_dout", rsp_dout, e.data);
      last_dout = e.data;
    end else begin
      check("rsp0_quiet", rsp0_valid, 0);
      check("rsp1_quiet", rsp1_valid, 0);
      check("rsp_hold", rsp_dout, last_dout);
    end
  endtask
  task automatic do_reset();
    rstb0 = 1'b0;
    tv[0] = 1'b1; tv[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rst_csb", csb0, 1);
      check("rst_web", web0, 1);
      check("rst_addr", ADDR0, 0);
      check("rst_din", DIN0, 0);
      check("rst_rsp0", rsp0_valid, 0);
      check("rst_rsp1", rsp1_valid, 0);
      check("rst_dout", rsp_dout, 0);
      check("rst_init_done", init_done, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      if (k == 0) @(posedge clk0);
    end
    rstb0 = 1'b1;
    init_k = 0; ptr = 0; last_dout = 0;
    exp_q.delete();
    idle();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    @(posedge clk0);
    #1;
    do_reset();
    repeat (16) step();
    tv[0] = 1; tw[0] = 1; ta[0] = 5;
    step();
    idle();
    repeat (2) step();
    check("rsp_drained_a", exp_q.size(), 0);
    tv[1] = 1; tw[1] = 0; ta[1] = 3; td[1] = 2'b10;
    step();
    tw[1] = 1;
    step();
    idle();
    repeat (2) step();
    check("rsp_drained_b", exp_q.size(), 0);
    repeat (200) begin rand_in(); step(); end
    idle();
    tv[0] = 1; tw[0] = 1; ta[0] = 4'($urandom_range(0, 15));
    step();
    do_reset();
    repeat (16) begin rand_in(); step(); end
    for (int i = 0; i < 6; i++) begin
      tv[0] = 1; tw[0] = 1; ta[0] = 4'(i);
      tv[1] = 1; tw[1] = 1; ta[1] = 4'(i + 8);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tv[1] = 1; tw[1] = i[0]; ta[1] = 4'(i + 2); td[1] = 2'(i + 1);
      step();
    end
    repeat (200) begin rand_in(); step(); end
    idle();
    repeat (3) step();
    check("rsp_drained_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
